// File: rtl/apb_pkg.sv
// apb_pkg: shared FSM states, slave-select codes and default timeout for the APB master
package apb_pkg;
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;
  localparam logic [1:0] SEL_S1 = 2'b00;
  localparam logic [1:0] SEL_S2 = 2'b01;
  localparam int TIMEOUT_DEF = 15;
endpackage

// File: rtl/apb_addr_decode.sv
// apb_addr_decode: maps the upper address bits to a slave select or a decode error
module apb_addr_decode
  import apb_pkg::*;
(
  input  logic [1:0] slv,
  output logic       sel1,
  output logic       sel2,
  output logic       dec_err
);
  always_comb begin
    sel1 = slv == SEL_S1;
    sel2 = slv == SEL_S2;
    dec_err = slv[1];
  end
endmodule

// File: rtl/apb_master.sv
// apb_master: single-outstanding APB master bridging a local command port to two slaves
module apb_master
  import apb_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic       PCLK,
  input  logic       PRESETn,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_write,
  input  logic [7:0] cmd_addr,
  input  logic [7:0] cmd_wdata,
  output logic       rsp_valid,
  output logic [7:0] rsp_rdata,
  output logic       rsp_err,
  output logic       PSEL1,
  output logic       PSEL2,
  output logic       PENABLE,
  output logic       PWRITE,
  output logic [7:0] PADDR,
  output logic [7:0] PWDATA,
  input  logic [7:0] PRDATA1,
  input  logic [7:0] PRDATA2,
  input  logic       PREADY1,
  input  logic       PREADY2
);
  localparam int CW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);
  state_t state;
  logic [CW-1:0] wait_cnt;
  logic sel1, sel2, dec_err, accept, pready;
  logic [7:0] prdata;
  apb_addr_decode u_dec (
    .slv     (cmd_addr[7:6]),
    .sel1    (sel1),
    .sel2    (sel2),
    .dec_err (dec_err)
  );
  // only the selected slave's handshake is observed
  always_comb begin
    cmd_ready = (state == IDLE) && PRESETn;
    accept = cmd_valid && cmd_ready;
    pready = PSEL1 ? PREADY1 : PREADY2;
    prdata = PSEL1 ? PRDATA1 : PRDATA2;
  end
  always_ff @(posedge PCLK) begin
    if (!PRESETn) begin
      state <= IDLE;
      PSEL1 <= 1'b0;
      PSEL2 <= 1'b0;
      PENABLE <= 1'b0;
      PWRITE <= 1'b0;
      PADDR <= '0;
      PWDATA <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err <= 1'b0;
      wait_cnt <= '0;
    end else begin
      rsp_valid <= 1'b0;
      rsp_err <= 1'b0;
      case (state)
        IDLE: if (accept) begin
          if (dec_err) begin
            rsp_valid <= 1'b1;
            rsp_err <= 1'b1;
            rsp_rdata <= '0;
          end else begin
            state <= SETUP;
            PSEL1 <= sel1;
            PSEL2 <= sel2;
            PWRITE <= cmd_write;
            PADDR <= {2'b00, cmd_addr[5:0]};
            PWDATA <= cmd_write ? cmd_wdata : '0;
            wait_cnt <= '0;
          end
        end
        SETUP: begin
          state <= ACCESS;
          PENABLE <= 1'b1;
        end
        ACCESS: begin
          if (!pready) wait_cnt <= wait_cnt + 1'b1;
          // abort once this cycle brings the wait count to TIMEOUT
          if (pready || wait_cnt == LAST) begin
            state <= IDLE;
            PSEL1 <= 1'b0;
            PSEL2 <= 1'b0;
            PENABLE <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_err <= !pready;
            rsp_rdata <= (pready && !PWRITE) ? prdata : '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_apb_master.sv
// tb_apb_master: table-driven directed checks plus hand sequences for timeout, reset and back-to-back
module tb_apb_master;
  typedef struct {
    logic wr;
    logic [7:0] addr, wdata, pr1, pr2;
    int waits;
    logic e_s1, e_s2, e_err;
    logic [7:0] e_paddr, e_pwdata, e_rdata;
  } vec_t;
  logic PCLK = 1'b0, PRESETn = 1'b0, cmd_valid = 1'b0, cmd_write = 1'b0;
  logic [7:0] cmd_addr = '0, cmd_wdata = '0, PRDATA1 = '0, PRDATA2 = '0;
  logic PREADY1 = 1'b1, PREADY2 = 1'b1;
  logic cmd_ready, rsp_valid, rsp_err, PSEL1, PSEL2, PENABLE, PWRITE;
  logic [7:0] rsp_rdata, PADDR, PWDATA;
  int errors = 0, checks = 0;
  vec_t vecs [7];

  apb_master #(.TIMEOUT(15)) dut (
    .PCLK(PCLK), .PRESETn(PRESETn), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_write(cmd_write), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .PSEL1(PSEL1), .PSEL2(PSEL2), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA1(PRDATA1), .PRDATA2(PRDATA2),
    .PREADY1(PREADY1), .PREADY2(PREADY2)
  );

  always #5 PCLK = ~PCLK;

  task automatic tick;
    @(posedge PCLK);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v, input int n);
    string p;
    p = $sformatf("v%0d", n);
    cmd_write = v.wr;
    cmd_addr = v.addr;
    cmd_wdata = v.wdata;
    PRDATA1 = v.pr1;
    PRDATA2 = v.pr2;
    PREADY1 = !v.e_s1;
    PREADY2 = !v.e_s2;
    cmd_valid = 1'b1;
    chk({p, "_cmd_ready"}, cmd_ready, 1);
    tick;
    cmd_valid = 1'b0;
    if (v.e_err) begin
      chk({p, "_err_valid"}, rsp_valid, 1);
      chk({p, "_err_flag"}, rsp_err, 1);
      chk({p, "_err_rdata"}, rsp_rdata, 0);
      chk({p, "_err_psel"}, {PSEL1, PSEL2, PENABLE}, 0);
      chk({p, "_err_ready"}, cmd_ready, 1);
    end else begin
      chk({p, "_setup_psel"}, {PSEL1, PSEL2}, {v.e_s1, v.e_s2});
      chk({p, "_setup_penable"}, PENABLE, 0);
      chk({p, "_setup_paddr"}, PADDR, v.e_paddr);
      chk({p, "_setup_pwdata"}, PWDATA, v.e_pwdata);
      chk({p, "_setup_pwrite"}, PWRITE, v.wr);
      chk({p, "_setup_ready"}, cmd_ready, 0);
      for (int i = 0; i <= v.waits; i++) begin
        tick;
        chk({p, $sformatf("_acc%0d_penable", i)}, PENABLE, 1);
        chk({p, $sformatf("_acc%0d_psel", i)}, {PSEL1, PSEL2}, {v.e_s1, v.e_s2});
        chk({p, $sformatf("_acc%0d_paddr", i)}, PADDR, v.e_paddr);
        chk({p, $sformatf("_acc%0d_pwdata", i)}, PWDATA, v.e_pwdata);
        chk({p, $sformatf("_acc%0d_rsp_valid", i)}, rsp_valid, 0);
        if (i == v.waits) begin
          PREADY1 = 1'b1;
          PREADY2 = 1'b1;
        end
      end
      tick;
      chk({p, "_done_valid"}, rsp_valid, 1);
      chk({p, "_done_err"}, rsp_err, 0);
      chk({p, "_done_rdata"}, rsp_rdata, v.e_rdata);
      chk({p, "_done_psel"}, {PSEL1, PSEL2, PENABLE}, 0);
      chk({p, "_done_paddr_hold"}, PADDR, v.e_paddr);
      chk({p, "_done_ready"}, cmd_ready, 1);
    end
    PREADY1 = 1'b1;
    PREADY2 = 1'b1;
    tick;
    chk({p, "_after_valid"}, rsp_valid, 0);
  endtask

  initial begin
    int acc;
    logic done;
    vecs[0] = '{1'b1, 8'h05, 8'hA5, 8'h00, 8'h00, 0, 1'b1, 1'b0, 1'b0, 8'h05, 8'hA5, 8'h00};
    vecs[1] = '{1'b0, 8'h45, 8'h99, 8'h77, 8'h3C, 2, 1'b0, 1'b1, 1'b0, 8'h05, 8'h00, 8'h3C};
    vecs[2] = '{1'b1, 8'h80, 8'h12, 8'h00, 8'h00, 0, 1'b0, 1'b0, 1'b1, 8'h00, 8'h00, 8'h00};
    vecs[3] = '{1'b0, 8'h3F, 8'h00, 8'hC3, 8'h11, 1, 1'b1, 1'b0, 1'b0, 8'h3F, 8'h00, 8'hC3};
    vecs[4] = '{1'b1, 8'h7E, 8'h5A, 8'h66, 8'h44, 0, 1'b0, 1'b1, 1'b0, 8'h3E, 8'h5A, 8'h00};
    vecs[5] = '{1'b0, 8'hC1, 8'h00, 8'hAA, 8'hBB, 0, 1'b0, 1'b0, 1'b1, 8'h00, 8'h00, 8'h00};
    vecs[6] = '{1'b0, 8'h00, 8'h00, 8'hFF, 8'h01, 3, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 8'hFF};
    tick;
    tick;
    chk("rst_psel", {PSEL1, PSEL2, PENABLE, PWRITE}, 0);
    chk("rst_paddr", PADDR, 0);
    chk("rst_pwdata", PWDATA, 0);
    chk("rst_rsp", {rsp_valid, rsp_err}, 0);
    chk("rst_rdata", rsp_rdata, 0);
    chk("rst_cmd_ready", cmd_ready, 0);
    PRESETn = 1'b1;
    tick;
    chk("rst_rel_ready", cmd_ready, 1);
    for (int n = 0; n < 7; n++) run_vec(vecs[n], n);
    // timeout: slave 1 never ready, slave 2 ready must be ignored
    cmd_write = 1'b0;
    cmd_addr = 8'h10;
    PRDATA1 = 8'hEE;
    PREADY1 = 1'b0;
    PREADY2 = 1'b1;
    cmd_valid = 1'b1;
    tick;
    cmd_valid = 1'b0;
    acc = 0;
    done = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      tick;
      if (rsp_valid) done = 1'b1;
      else if (PENABLE) acc++;
    end
    chk("to_done", done, 1);
    chk("to_access_cycles", acc, 15);
    chk("to_err", rsp_err, 1);
    chk("to_rdata", rsp_rdata, 0);
    chk("to_ready", cmd_ready, 1);
    chk("to_psel", {PSEL1, PSEL2, PENABLE}, 0);
    PREADY1 = 1'b1;
    tick;
    // reset during ACCESS
    cmd_write = 1'b1;
    cmd_addr = 8'h47;
    cmd_wdata = 8'h99;
    PREADY2 = 1'b0;
    cmd_valid = 1'b1;
    tick;
    cmd_valid = 1'b0;
    tick;
    chk("ra_in_access", {PSEL2, PENABLE}, 2'b11);
    PRESETn = 1'b0;
    tick;
    chk("ra_psel", {PSEL1, PSEL2, PENABLE, PWRITE}, 0);
    chk("ra_paddr", PADDR, 0);
    chk("ra_pwdata", PWDATA, 0);
    chk("ra_rsp", {rsp_valid, rsp_err}, 0);
    chk("ra_rdata", rsp_rdata, 0);
    chk("ra_ready", cmd_ready, 0);
    PRESETn = 1'b1;
    PREADY2 = 1'b1;
    tick;
    chk("ra_no_valid", rsp_valid, 0);
    chk("ra_ready_back", cmd_ready, 1);
    run_vec(vecs[0], 10);
    // back-to-back with cmd_valid held high
    PREADY1 = 1'b1;
    PREADY2 = 1'b1;
    cmd_write = 1'b1;
    cmd_addr = 8'h01;
    cmd_wdata = 8'h11;
    cmd_valid = 1'b1;
    tick;
    chk("bb_setup1", {PSEL1, PADDR, PWDATA}, {1'b1, 8'h01, 8'h11});
    cmd_addr = 8'h42;
    cmd_wdata = 8'h22;
    tick;
    chk("bb_access1_hold", {PSEL1, PSEL2, PENABLE, PADDR, PWDATA}, {3'b101, 8'h01, 8'h11});
    chk("bb_access1_ready", cmd_ready, 0);
    tick;
    chk("bb_rsp1", {rsp_valid, rsp_err}, 2'b10);
    chk("bb_rsp1_ready", cmd_ready, 1);
    tick;
    cmd_valid = 1'b0;
    chk("bb_setup2", {PSEL1, PSEL2, PENABLE, PADDR, PWDATA}, {3'b010, 8'h02, 8'h22});
    chk("bb_setup2_valid", rsp_valid, 0);
    tick;
    chk("bb_access2", {PSEL2, PENABLE}, 2'b11);
    tick;
    chk("bb_rsp2", {rsp_valid, rsp_err, rsp_rdata}, {2'b10, 8'h00});
    tick;
    chk("bb_idle", {rsp_valid, PSEL1, PSEL2, cmd_ready}, 4'b0001);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/apb_master.md
APB_MASTER -- requirements
Module: apb_master

Interface
REQ-001 Parameter TIMEOUT, default 15; maximum ACCESS-phase wait cycles before abort.
REQ-002 PCLK  input  1  APB clock; all state changes on rising edge.
REQ-003 PRESETn  input  1  reset; synchronous, active-low.
REQ-004 cmd_valid  input  1  command request from local host.
REQ-005 cmd_ready  output  1  master can accept a command.
REQ-006 cmd_write  input  1  1 = write, 0 = read.
REQ-007 cmd_addr  input  8  target address; [7:6] selects slave, [5:0] is the offset.
REQ-008 cmd_wdata  input  8  write data.
REQ-009 rsp_valid  output  1  one-cycle completion pulse.
REQ-010 rsp_rdata  output  8  read data; 0 for writes and errors.
REQ-011 rsp_err  output  1  completion was a decode error or timeout; qualified by rsp_valid.
REQ-012 PSEL1, PSEL2  output  1 each  slave selects.
REQ-013 PENABLE, PWRITE  output  1 each  APB phase control and direction.
REQ-014 PADDR, PWDATA  output  8 each  APB address and write data.
REQ-015 PRDATA1, PRDATA2  input  8 each  slave read data.
REQ-016 PREADY1, PREADY2  input  1 each  slave ready signals.

Function
REQ-017 The FSM SHALL use three states: IDLE, SETUP and ACCESS.
REQ-018 cmd_ready SHALL equal (state==IDLE && PRESETn).
REQ-019 A command SHALL be accepted on a rising edge when cmd_valid && cmd_ready; cmd_write, cmd_addr and cmd_wdata SHALL be registered on that edge.
REQ-020 Slave decode SHALL be: cmd_addr[7:6]==00 selects slave 1; 01 selects slave 2; 1x is a decode error.
REQ-021 On a decode error the FSM SHALL stay in IDLE, assert no PSEL, and pulse rsp_valid=1 with rsp_err=1 in the next cycle.
REQ-022 For a valid slave the FSM SHALL move IDLE->SETUP.
REQ-023 In SETUP: selected PSELx=1, PENABLE=0, PADDR={2'b00, offset}, and PWRITE/PWDATA driven from the registered command (PWDATA=0 for reads).
REQ-024 The FSM SHALL move SETUP->ACCESS unconditionally after one cycle.
REQ-025 In ACCESS: PENABLE=1, and PSELx, PADDR, PWRITE and PWDATA SHALL be held stable.
REQ-026 In ACCESS, the selected PREADYx sampled high SHALL complete the transfer: go to IDLE and capture rsp_rdata = selected PRDATAx (reads) or 0 (writes).
REQ-027 rsp_valid SHALL be high for exactly the cycle after completion, with rsp_err=0.
REQ-028 A wait counter (width ceil(log2(TIMEOUT+1))) SHALL clear on SETUP entry and increment each ACCESS cycle that has PREADYx low.
REQ-029 When the wait counter reaches TIMEOUT with PREADYx still low, the FSM SHALL go to IDLE and pulse rsp_valid with rsp_err=1 and rsp_rdata=0.
REQ-030 The non-selected slave's PREADY and PRDATA SHALL be ignored.
REQ-031 Outside SETUP/ACCESS: PSEL1=PSEL2=PENABLE=0; PADDR, PWDATA and PWRITE hold their last values.
REQ-032 Zero-wait latency SHALL be: accept edge N -> SETUP cycle N+1 -> ACCESS cycle N+2 -> rsp_valid in cycle N+3.
REQ-033 The minimum command spacing SHALL be 3 cycles, with no pipelining.
REQ-034 A new command SHALL be acceptable in the same cycle that rsp_valid is high.
REQ-035 cmd_valid while not in IDLE SHALL be ignored, and no command is lost (cmd_ready=0).

Reset
REQ-036 When PRESETn is low at a rising edge, the FSM SHALL enter IDLE and clear: PSEL1, PSEL2, PENABLE, PWRITE, PADDR, PWDATA, rsp_valid, rsp_rdata, rsp_err and the wait counter.
REQ-037 Reset during SETUP or ACCESS SHALL abort the transfer with no rsp_valid pulse.
REQ-038 Outputs SHALL be 0 in the cycle following the reset edge.

Structure
REQ-039 Package apb_pkg SHALL hold the FSM state enum (IDLE, SETUP, ACCESS), the slave-select codes (SEL_S1=2'b00, SEL_S2=2'b01) and the default TIMEOUT.
REQ-040 One sub-module, apb_addr_decode, SHALL be combinational: cmd_addr[7:6] -> {sel1, sel2, dec_err}.
REQ-041 The FSM, wait counter, output registers and response mux SHALL live in apb_master.

Verification
REQ-042 Write 0x05 <- 0xA5 to slave 1 with zero-wait PREADY1 -> PSEL1=1 in cycles N+1..N+2, PENABLE=1 in N+2, PADDR=0x05, PWDATA=0xA5; rsp_valid in N+3 with rsp_err=0.
REQ-043 Read 0x45 from slave 2 with PRDATA2=0x3C and PREADY2 low for 2 ACCESS cycles -> PADDR=0x05, PSEL2 only, PENABLE held 3 cycles; rsp_rdata=0x3C, rsp_err=0.
REQ-044 Command to address 0x80 -> no PSEL asserted; rsp_valid with rsp_err=1 in the next cycle.
REQ-045 Slave 1 PREADY1 stuck low with TIMEOUT=15 -> abort after 15 ACCESS cycles; rsp_err=1, rsp_rdata=0; cmd_ready returns to 1.
REQ-046 PRESETn low in the ACCESS cycle -> next cycle all outputs 0, no rsp_valid; a fresh write then completes normally.
REQ-047 Back-to-back commands with cmd_valid held high -> second accepted in the rsp_valid cycle; cmd_valid asserted during SETUP/ACCESS is not accepted.
